// File: rtl/vehicle_actuator_model_pkg.sv
// rtl/vehicle_actuator_model_pkg.sv - state encoding, speed width and saturating helper
package vehicle_act_pkg;

   localparam int SPEED_W = 8;

   localparam logic [1:0] ACT_COAST = 2'b00;
   localparam logic [1:0] ACT_BRAKE = 2'b01;
   localparam logic [1:0] ACT_ACCEL = 2'b10;
   localparam logic [1:0] ACT_HOLD  = 2'b11;

   // State value doubles as the {gas,brake} command that selects it.
   typedef enum logic [1:0] {
      ST_COAST = ACT_COAST,
      ST_BRAKE = ACT_BRAKE,
      ST_ACCEL = ACT_ACCEL,
      ST_HOLD  = ACT_HOLD
   } act_state_e;

   function automatic logic [SPEED_W-1:0] sat_sub(input logic [SPEED_W-1:0] a,
                                                  input logic [SPEED_W-1:0] b);
      return (a < b) ? '0 : a - b;
   endfunction

endpackage

// File: rtl/vehicle_actuator_model_if.sv
// rtl/vehicle_actuator_model_if.sv - gas/brake command and speed/tick feedback bundle
interface vehicle_actuator_model_if;
   import vehicle_act_pkg::*;

   logic               gas_i;
   logic               brake_i;
   logic               timer_trick_o;
   logic [SPEED_W-1:0] speed_measured_o;
   logic [1:0]         act_state_o;
   logic               stopped_o;

   modport master (
      output gas_i, brake_i,
      input  timer_trick_o, speed_measured_o, act_state_o, stopped_o
   );

   modport slave (
      input  gas_i, brake_i,
      output timer_trick_o, speed_measured_o, act_state_o, stopped_o
   );

endinterface

// File: rtl/vehicle_actuator_model_tick_gen.sv
// rtl/vehicle_actuator_model_tick_gen.sv - free-running divider producing a registered one-cycle tick
module tick_gen #(
   parameter int TICK_DIV = 16
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int CNT_W = $clog2(TICK_DIV);

   logic [CNT_W-1:0] cnt;

   // Tick is registered from the TICK_DIV-2 compare so it lines up with cnt == TICK_DIV-1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else begin
         cnt  <= (cnt == CNT_W'(TICK_DIV - 1)) ? '0 : cnt + CNT_W'(1);
         tick <= (cnt == CNT_W'(TICK_DIV - 2));
      end
   end

endmodule

// File: rtl/vehicle_actuator_model.sv
// rtl/vehicle_actuator_model.sv - actuator FSM and saturating speed integrator driven by the timer tick
// Optional: ACT_DEBOUNCE_EN requires a command to repeat on two consecutive ticks before it applies.
module vehicle_actuator_model
   import vehicle_act_pkg::*;
#(
   parameter int TICK_DIV   = 16,
   parameter int ACCEL_STEP = 2,
   parameter int BRAKE_STEP = 4,
   parameter int COAST_DIV  = 4,
   parameter int MAX_SPEED  = 200
) (
   input  logic                      clk,
   input  logic                      rst_n,
   vehicle_actuator_model_if.slave   bus
);

   logic               tick;
   logic [1:0]         cmd;
   act_state_e         state_q, state_d;
   logic [SPEED_W-1:0] speed_q, speed_d;
   logic [7:0]         coast_q, coast_d;
   logic [SPEED_W:0]   accel_sum;
`ifdef ACT_DEBOUNCE_EN
   logic [1:0]         last_q;
`endif

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   assign cmd = {bus.gas_i, bus.brake_i};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_COAST;
         speed_q <= '0;
         coast_q <= '0;
      end else begin
         state_q <= state_d;
         speed_q <= speed_d;
         coast_q <= coast_d;
      end
   end

`ifdef ACT_DEBOUNCE_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last_q <= 2'b00;
      else if (tick)
         last_q <= cmd;
   end
`endif

   // Speed action is chosen from the state being entered on this tick, not the old one.
   always_comb begin
      state_d   = state_q;
      speed_d   = speed_q;
      coast_d   = coast_q;
      accel_sum = {1'b0, speed_q} + (SPEED_W+1)'(ACCEL_STEP);
      if (tick) begin
`ifdef ACT_DEBOUNCE_EN
         if (cmd == last_q)
            state_d = act_state_e'(cmd);
`else
         state_d = act_state_e'(cmd);
`endif
         coast_d = '0;
         case (state_d)
            ST_ACCEL: speed_d = (accel_sum > (SPEED_W+1)'(MAX_SPEED)) ? SPEED_W'(MAX_SPEED)
                                                                     : accel_sum[SPEED_W-1:0];
            ST_BRAKE: speed_d = sat_sub(speed_q, SPEED_W'(BRAKE_STEP));
            ST_COAST: begin
               if (coast_q == 8'(COAST_DIV - 1))
                  speed_d = sat_sub(speed_q, SPEED_W'(1));
               else
                  coast_d = coast_q + 8'd1;
            end
            default:  speed_d = speed_q;
         endcase
      end
   end

   assign bus.timer_trick_o    = tick;
   assign bus.speed_measured_o = speed_q;
   assign bus.act_state_o      = state_q;
   assign bus.stopped_o        = (speed_q == '0);

endmodule

// File: tb/tb_vehicle_actuator_model.sv
// tb/tb_vehicle_actuator_model.sv - directed bench with a cycle-level behavioural model of the actuator
module tb_vehicle_actuator_model;

   localparam int TD  = 16;
   localparam int AS  = 2;
   localparam int BS  = 4;
   localparam int CD  = 4;
   localparam int MAX = 200;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   vehicle_actuator_model_if bus();

   vehicle_actuator_model #(
      .TICK_DIV(TD), .ACCEL_STEP(AS), .BRAKE_STEP(BS), .COAST_DIV(CD), .MAX_SPEED(MAX)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Model: cycles since reset release, speed as a plain integer, consecutive coast ticks.
   int         m_cyc = 0;
   int         m_speed = 0;
   int         m_state = 0;
   int         m_coast_run = 0;
   logic [1:0] m_last = 2'b00;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cyc = 0; m_speed = 0; m_state = 0; m_coast_run = 0; m_last = 2'b00;
      end else begin
         if (m_cyc % TD == TD - 1) begin
`ifdef ACT_DEBOUNCE_EN
            if ({bus.gas_i, bus.brake_i} == m_last) m_state = int'({bus.gas_i, bus.brake_i});
            m_last = {bus.gas_i, bus.brake_i};
`else
            m_state = int'({bus.gas_i, bus.brake_i});
`endif
            if (m_state == 2) m_speed = (m_speed + AS > MAX) ? MAX : m_speed + AS;
            if (m_state == 1) m_speed = (m_speed < BS) ? 0 : m_speed - BS;
            if (m_state == 0) begin
               m_coast_run++;
               if (m_coast_run % CD == 0 && m_speed > 0) m_speed--;
            end else begin
               m_coast_run = 0;
            end
         end
         m_cyc++;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("tick", int'(bus.timer_trick_o), (rst_n && (m_cyc % TD == TD - 1)) ? 1 : 0);
      check("speed", int'(bus.speed_measured_o), m_speed);
      check("state", int'(bus.act_state_o), m_state);
      check("stopped", int'(bus.stopped_o), (m_speed == 0) ? 1 : 0);
   end

   // Called on a negedge; returns on the negedge after the tick edge, with n = negedges waited.
   task automatic next_tick(output int n);
      n = 0;
      while (bus.timer_trick_o !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) begin
         checks++;
         failures++;
         $display("FAIL tick_timeout actual=%0d expected=<40", n);
      end
      @(negedge clk);
   endtask

   task automatic run_ticks(input logic g, input logic b, input int count);
      int n;
      bus.gas_i = g;
      bus.brake_i = b;
      for (int i = 0; i < count; i++) next_tick(n);
   endtask

   initial begin
      int n;
      bus.gas_i = 1'b0;
      bus.brake_i = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_speed", int'(bus.speed_measured_o), 0);
      check("rst_state", int'(bus.act_state_o), 0);
      check("rst_stopped", int'(bus.stopped_o), 1);
      check("rst_tick", int'(bus.timer_trick_o), 0);
      rst_n = 1'b1;

      // First tick sits in cycle 16: 15 edges after release, then every 16.
      next_tick(n);
      check("first_tick_gap", n, 15);
      next_tick(n);
      check("tick_period", n + 1, 16);
      check("idle_speed", int'(bus.speed_measured_o), 0);

`ifdef ACT_DEBOUNCE_EN
      run_ticks(1'b1, 1'b0, 1);
      run_ticks(1'b0, 1'b0, 1);
      check("db_pulse_speed", int'(bus.speed_measured_o), 0);
      check("db_pulse_state", int'(bus.act_state_o), 0);
      run_ticks(1'b1, 1'b0, 1);
      check("db_first_speed", int'(bus.speed_measured_o), 0);
      run_ticks(1'b1, 1'b0, 1);
      check("db_second_speed", int'(bus.speed_measured_o), 2);
      check("db_second_state", int'(bus.act_state_o), 2);
`else
      for (int i = 1; i <= 5; i++) begin
         run_ticks(1'b1, 1'b0, 1);
         check("accel_ramp", int'(bus.speed_measured_o), 2 * i);
         check("accel_state", int'(bus.act_state_o), 2);
      end

      run_ticks(1'b0, 1'b0, 3);
      check("coast_t3", int'(bus.speed_measured_o), 10);
      run_ticks(1'b0, 1'b0, 1);
      check("coast_t4", int'(bus.speed_measured_o), 9);
      run_ticks(1'b0, 1'b0, 4);
      check("coast_t8", int'(bus.speed_measured_o), 8);

      run_ticks(1'b1, 1'b0, 21);
      check("reach_50", int'(bus.speed_measured_o), 50);
      run_ticks(1'b1, 1'b1, 1);
      check("hold_speed", int'(bus.speed_measured_o), 50);
      check("hold_state", int'(bus.act_state_o), 3);
      bus.gas_i = 1'b0;
      repeat (5) @(negedge clk);
      check("midtoggle_speed", int'(bus.speed_measured_o), 50);
      check("midtoggle_state", int'(bus.act_state_o), 3);
      run_ticks(1'b1, 1'b1, 1);
      check("hold_after", int'(bus.speed_measured_o), 50);

      run_ticks(1'b0, 1'b0, 4);
      check("coast_49", int'(bus.speed_measured_o), 49);
      run_ticks(1'b1, 1'b0, 75);
      check("reach_199", int'(bus.speed_measured_o), 199);
      run_ticks(1'b1, 1'b0, 1);
      check("sat_200", int'(bus.speed_measured_o), 200);
      run_ticks(1'b1, 1'b0, 1);
      check("sat_stay", int'(bus.speed_measured_o), 200);
      run_ticks(1'b0, 1'b0, 4);
      run_ticks(1'b0, 1'b1, 49);
      check("brake_3", int'(bus.speed_measured_o), 3);
      run_ticks(1'b0, 1'b1, 1);
      check("brake_floor", int'(bus.speed_measured_o), 0);
      check("brake_stopped", int'(bus.stopped_o), 1);

      run_ticks(1'b1, 1'b0, 20);
      check("reach_40", int'(bus.speed_measured_o), 40);
      repeat (4) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_speed", int'(bus.speed_measured_o), 0);
      check("async_state", int'(bus.act_state_o), 0);
      check("async_stopped", int'(bus.stopped_o), 1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      next_tick(n);
      check("restart_gap", n, 15);
      check("restart_speed", int'(bus.speed_measured_o), 2);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
